// File: rtl/multi_timer.sv
// NrTimers-channel prescaled compare timer on the simple-system bus (1 KiB window).
// Optional macro MULTI_TIMER_CHAIN_EN: channel n may tick on channel n-1's match.
module multi_timer #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned NrTimers      = 4,
  parameter int unsigned PrescaleWidth = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      timer_req_i,
  input  logic                      timer_we_i,
  input  logic [DataWidth/8-1:0]    timer_be_i,
  input  logic [AddressWidth-1:0]   timer_addr_i,
  input  logic [DataWidth-1:0]      timer_wdata_i,
  output logic                      timer_rvalid_o,
  output logic [DataWidth-1:0]      timer_rdata_o,
  output logic                      timer_err_o,
  output logic [NrTimers-1:0]       timer_intr_o,
  output logic                      timer_intr_any_o
);

  localparam int unsigned BeWidth = DataWidth / 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [DataWidth-1:0] merge_be(
    input logic [DataWidth-1:0] old_val,
    input logic [DataWidth-1:0] new_val,
    input logic [BeWidth-1:0]   be
  );
    logic [DataWidth-1:0] res;
    res = old_val;
    for (int b = 0; b < int'(BeWidth); b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Channel state
  state_e                   state_q   [NrTimers];
  state_e                   state_d   [NrTimers];
  logic [PrescaleWidth-1:0] presc_q   [NrTimers];
  logic [PrescaleWidth-1:0] presc_d   [NrTimers];
  logic [PrescaleWidth-1:0] psc_q     [NrTimers];
  logic [PrescaleWidth-1:0] psc_d     [NrTimers];
  logic [DataWidth-1:0]     count_q   [NrTimers];
  logic [DataWidth-1:0]     count_d   [NrTimers];
  logic [DataWidth-1:0]     cmp_q     [NrTimers];
  logic [DataWidth-1:0]     cmp_d     [NrTimers];
  logic [NrTimers-1:0]      periodic_q, periodic_d;
  logic [NrTimers-1:0]      pending_q, pending_d;
  logic [NrTimers-1:0]      ie_q, ie_d;
  logic [NrTimers-1:0]      intr_q;
`ifdef MULTI_TIMER_CHAIN_EN
  logic [NrTimers-1:0]      chain_q, chain_d;
`endif

  logic [NrTimers-1:0]      en, tick, match;
  logic [NrTimers-1:0]      ctrl_wr, count_wr, cmp_wr, stat_wr;

  // Bus decode
  logic [3:0]           ch;
  logic [1:0]           rsel;
  logic                 hit, wr, rd;
  logic [DataWidth-1:0] rdata_d;
  logic                 rvalid_q, err_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 unused_addr;

  assign ch   = timer_addr_i[7:4];
  assign rsel = timer_addr_i[3:2];
  assign hit  = (timer_addr_i[9:8] == 2'b00) && (ch < 4'(NrTimers));
  assign wr   = timer_req_i && timer_we_i && hit;
  assign rd   = timer_req_i && !timer_we_i && hit;
  assign unused_addr = ^{timer_addr_i[AddressWidth-1:10], timer_addr_i[1:0]};

  always_comb begin
    ctrl_wr  = '0;
    count_wr = '0;
    cmp_wr   = '0;
    stat_wr  = '0;
    for (int n = 0; n < int'(NrTimers); n++) begin
      if (wr && ch == 4'(n)) begin
        case (rsel)
          2'd0:    ctrl_wr[n]  = 1'b1;
          2'd1:    count_wr[n] = 1'b1;
          2'd2:    cmp_wr[n]   = 1'b1;
          default: stat_wr[n]  = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    for (int n = 0; n < int'(NrTimers); n++) begin
      en[n] = (state_q[n] == RUN);
    end
  end

  // Channel next-state: prescaler, tick/match, counter, IDLE/RUN machine
  always_comb begin
    logic prev_match;
    prev_match = 1'b0;
    tick       = '0;
    match      = '0;
    periodic_d = periodic_q;
    pending_d  = pending_q;
    ie_d       = ie_q;
`ifdef MULTI_TIMER_CHAIN_EN
    chain_d    = chain_q;
`endif
    for (int n = 0; n < int'(NrTimers); n++) begin
      state_d[n] = state_q[n];
      presc_d[n] = presc_q[n];
      psc_d[n]   = psc_q[n];
      count_d[n] = count_q[n];
      cmp_d[n]   = cmp_q[n];

`ifdef MULTI_TIMER_CHAIN_EN
      if (chain_q[n]) begin
        tick[n]  = en[n] && prev_match;
        psc_d[n] = '0;
      end else
`endif
      begin
        tick[n] = en[n] && (psc_q[n] == presc_q[n]);
        if (!en[n] || tick[n]) psc_d[n] = '0;
        else                   psc_d[n] = psc_q[n] + 1'b1;
      end
      if (ctrl_wr[n]) psc_d[n] = '0;

      // Compare uses the pre-increment count; wrap to zero is not a match
      match[n] = tick[n] && (count_q[n] == cmp_q[n]);

      if (count_wr[n]) begin
        count_d[n] = merge_be(count_q[n], timer_wdata_i, timer_be_i);
      end else if (tick[n]) begin
        if (!match[n])          count_d[n] = count_q[n] + 1'b1;
        else if (periodic_q[n]) count_d[n] = '0;
      end

      case (state_q[n])
        IDLE: if (ctrl_wr[n] && timer_be_i[0] && timer_wdata_i[0]) state_d[n] = RUN;
        RUN: begin
          if (ctrl_wr[n] && timer_be_i[0])     state_d[n] = timer_wdata_i[0] ? RUN : IDLE;
          else if (match[n] && !periodic_q[n]) state_d[n] = IDLE;
        end
        default: state_d[n] = IDLE;
      endcase

      if (ctrl_wr[n] && timer_be_i[0]) begin
        periodic_d[n] = timer_wdata_i[1];
`ifdef MULTI_TIMER_CHAIN_EN
        if (n > 0) chain_d[n] = timer_wdata_i[2];
`endif
      end
      if (ctrl_wr[n] && timer_be_i[1]) presc_d[n] = timer_wdata_i[8 +: PrescaleWidth];

      if (cmp_wr[n]) cmp_d[n] = merge_be(cmp_q[n], timer_wdata_i, timer_be_i);

      if (stat_wr[n] && timer_be_i[0]) begin
        ie_d[n] = timer_wdata_i[1];
        if (timer_wdata_i[0]) pending_d[n] = 1'b0;
      end
      if (match[n]) pending_d[n] = 1'b1;

      prev_match = match[n];
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int n = 0; n < int'(NrTimers); n++) begin
      if (rd && ch == 4'(n)) begin
        case (rsel)
          2'd0: begin
            rdata_d[0] = en[n];
            rdata_d[1] = periodic_q[n];
`ifdef MULTI_TIMER_CHAIN_EN
            rdata_d[2] = chain_q[n];
`endif
            rdata_d[8 +: PrescaleWidth] = presc_q[n];
          end
          2'd1: rdata_d = count_q[n];
          2'd2: rdata_d = cmp_q[n];
          default: begin
            rdata_d[0] = pending_q[n];
            rdata_d[1] = ie_q[n];
          end
        endcase
      end
    end
  end

  // Register stage: channel state and bus response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 0; n < int'(NrTimers); n++) begin
        state_q[n] <= IDLE;
        presc_q[n] <= '0;
        psc_q[n]   <= '0;
        count_q[n] <= '0;
        cmp_q[n]   <= '0;
      end
      periodic_q <= '0;
      pending_q  <= '0;
      ie_q       <= '0;
      intr_q     <= '0;
`ifdef MULTI_TIMER_CHAIN_EN
      chain_q    <= '0;
`endif
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      for (int n = 0; n < int'(NrTimers); n++) begin
        state_q[n] <= state_d[n];
        presc_q[n] <= presc_d[n];
        psc_q[n]   <= psc_d[n];
        count_q[n] <= count_d[n];
        cmp_q[n]   <= cmp_d[n];
      end
      periodic_q <= periodic_d;
      pending_q  <= pending_d;
      ie_q       <= ie_d;
      intr_q     <= pending_q & ie_q;
`ifdef MULTI_TIMER_CHAIN_EN
      chain_q    <= chain_d;
`endif
      rvalid_q   <= timer_req_i;
      err_q      <= timer_req_i && !hit;
      rdata_q    <= rdata_d;
    end
  end

  assign timer_rvalid_o   = rvalid_q;
  assign timer_err_o      = err_q;
  assign timer_rdata_o    = rdata_q;
  assign timer_intr_o     = intr_q;
  assign timer_intr_any_o = |intr_q;

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer (default 4 channels, 32-bit bus).
module tb_multi_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        rvalid, err, intr_any;
  logic [31:0] rdata;
  logic [3:0]  intr;

  int n_chk  = 0;
  int n_pass = 0;

  multi_timer dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .timer_req_i      (req),
    .timer_we_i       (we),
    .timer_be_i       (be),
    .timer_addr_i     (addr),
    .timer_wdata_i    (wdata),
    .timer_rvalid_o   (rvalid),
    .timer_rdata_o    (rdata),
    .timer_err_o      (err),
    .timer_intr_o     (intr),
    .timer_intr_any_o (intr_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One bus cycle: drive at a negedge, return at the next negedge with the response visible
  task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    req = r; we = w; addr = a; be = b; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, 4'hF, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b1, 1'b0, a, 4'h0, 32'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] exp0 [9];
    logic [31:0] exp2 [8];
    exp0 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    exp2 = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0};

    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_intr", {27'd0, intr_any, intr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All registers read zero after reset; out-of-range channel errors
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        rd(32'(c * 16 + r * 4));
        chk($sformatf("rst_rd_%0d_%0d", c, r), rdata, 32'd0);
      end
    end
    chk("rd_rvalid", 32'(rvalid), 32'd1);
    chk("rd_err0", 32'(err), 32'd0);
    idle();
    chk("idle_rvalid", 32'(rvalid), 32'd0);
    rd(32'h40);
    chk("oob_err", 32'(err), 32'd1);
    chk("oob_rdata", rdata, 32'd0);

    // Ch0 periodic, presc 0, COMPARE 3: COUNT 0,1,2,3,0,...
    wr(32'h08, 32'd3);
    wr(32'h0C, 32'h2);
    wr(32'h00, 32'h3);
    for (int i = 1; i <= 9; i++) begin
      rd(32'h04);
      chk($sformatf("ch0_count_%0d", i), rdata, exp0[i-1]);
      if (i == 4) chk("ch0_intr_early", 32'(intr[0]), 32'd0);
      if (i == 5) chk("ch0_intr_set", 32'(intr[0]), 32'd1);
    end
    chk("ch0_intr_any", 32'(intr_any), 32'd1);
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'h1);

    // Ch1 one-shot, presc 2, COMPARE 1: match on the 6th cycle, en drops, COUNT holds
    wr(32'h18, 32'd1);
    wr(32'h1C, 32'h2);
    wr(32'h10, 32'h0000_0201);
    for (int i = 1; i <= 8; i++) begin
      idle();
      if (i == 6) chk("ch1_intr_early", 32'(intr[1]), 32'd0);
      if (i == 7) chk("ch1_intr_set", 32'(intr[1]), 32'd1);
    end
    rd(32'h10);
    chk("ch1_ctrl_en0", rdata, 32'h0000_0200);
    rd(32'h14);
    chk("ch1_count_hold", rdata, 32'd1);
    wr(32'h1C, 32'h3);
    chk("ch1_intr_lag", 32'(intr[1]), 32'd1);
    idle();
    chk("ch1_intr_clr", 32'(intr[1]), 32'd0);
    rd(32'h1C);
    chk("ch1_status", rdata, 32'h2);

    // Ch2 wrap from all-ones without interrupt, then match at 5
    wr(32'h28, 32'd5);
    wr(32'h2C, 32'h2);
    wr(32'h24, 32'hFFFF_FFFF);
    wr(32'h20, 32'h3);
    for (int i = 1; i <= 8; i++) begin
      rd(32'h24);
      chk($sformatf("ch2_count_%0d", i), rdata, exp2[i-1]);
      if (i == 2) chk("ch2_wrap_nointr", 32'(intr[2]), 32'd0);
      if (i == 7) chk("ch2_intr_early", 32'(intr[2]), 32'd0);
      if (i == 8) chk("ch2_intr_set", 32'(intr[2]), 32'd1);
    end
    // COUNT write coinciding with a tick wins
    wr(32'h24, 32'h100);
    rd(32'h24);
    chk("ch2_wr_wins", rdata, 32'h100);
    rd(32'h24);
    chk("ch2_after_wr", rdata, 32'h101);
    // W1C coinciding with a match leaves pending set
    wr(32'h2C, 32'h3);
    rd(32'h2C);
    chk("ch2_w1c", rdata, 32'h2);
    wr(32'h24, 32'd4);
    idle();
    wr(32'h2C, 32'h3);
    rd(32'h2C);
    chk("ch2_set_wins", rdata, 32'h3);
    wr(32'h20, 32'h0);
    wr(32'h2C, 32'h1);

    // Byte enables on ch3
    wr(32'h30, 32'h2);
    cyc(1'b1, 1'b1, 32'h30, 4'b0010, 32'h0000_AB00);
    rd(32'h30);
    chk("be_presc", rdata, 32'h0000_AB02);
    cyc(1'b1, 1'b1, 32'h38, 4'b0000, 32'hFFFF_FFFF);
    rd(32'h38);
    chk("be_zero", rdata, 32'd0);
    cyc(1'b1, 1'b1, 32'h40, 4'hF, 32'hFFFF_FFFF);
    chk("wr_oob_err", 32'(err), 32'd1);
    rd(32'h100);
    chk("hi_addr_err", 32'(err), 32'd1);
    chk("hi_addr_rdata", rdata, 32'd0);
    rd(32'h30);
    chk("oob_nochange", rdata, 32'h0000_AB02);
    chk("ok_err0", 32'(err), 32'd0);

    // Channel 0 never reports chain
    wr(32'h00, 32'h4);
    rd(32'h00);
    chk("ch0_chain_rd", rdata, 32'd0);

`ifdef MULTI_TIMER_CHAIN_EN
    wr(32'h14, 32'd0);
    wr(32'h1C, 32'h3);
    wr(32'h18, 32'd2);
    wr(32'h10, 32'h5);
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd1);
    wr(32'h00, 32'h3);
    for (int i = 1; i <= 7; i++) begin
      idle();
      if (i == 6) chk("chain_intr_early", 32'(intr[1]), 32'd0);
      if (i == 7) chk("chain_intr_set", 32'(intr[1]), 32'd1);
    end
    rd(32'h10);
    chk("chain_ctrl", rdata, 32'h4);
`else
    wr(32'h10, 32'h4);
    rd(32'h10);
    chk("nochain_ctrl", rdata, 32'd0);
`endif

    // Reset in the middle of a run clears everything immediately
    wr(32'h0C, 32'h2);
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd0);
    wr(32'h00, 32'h3);
    repeat (3) idle();
    chk("pre_rst_intr", 32'(intr[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_intr", {27'd0, intr_any, intr}, 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h00);
    chk("post_rst_ctrl", rdata, 32'd0);
    rd(32'h1C);
    chk("post_rst_status", rdata, 32'd0);
    repeat (3) idle();
    chk("post_rst_intr", {27'd0, intr_any, intr}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
